// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Shared segment codes, anode patterns and digit-select type for
//            the two-digit multiplexed seven-segment display.
// Revision : 1.0  initial release
// ============================================================================
package seg7_pkg;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    // Active-low anodes: an[0] = ones, an[1] = tens
    localparam logic [1:0] AN_ONES  = 2'b10;
    localparam logic [1:0] AN_TENS  = 2'b01;
    localparam logic [1:0] AN_OFF   = 2'b11;

    typedef enum logic {
        SEL_ONES = 1'b0,
        SEL_TENS = 1'b1
    } digit_sel_e;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_decode
// Purpose  : BCD to active-low seven-segment decoder; non-BCD codes show a dash.
// Revision : 1.0  initial release
// ============================================================================
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule : seg7_decode
`default_nettype wire

// File: rtl/seg7_scan.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan
// Purpose  : Two-digit multiplexed seven-segment driver with load latch,
//            leading-zero blanking and blink; segment/anode outputs registered.
// Revision : 1.0  initial release
// ============================================================================
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int CLK_DIV     = 50000,
    parameter int BLINK_TICKS = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       load,
    input  logic       blank_lz,
    input  logic       blink_en,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       tick
);

    localparam int               DIV_W    = $clog2(CLK_DIV);
    localparam int               BLK_W    = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_TICKS - 1);

    logic [DIV_W-1:0] r_div;
    logic [BLK_W-1:0] r_blk_cnt;
    logic             r_phase;
    digit_sel_e       r_sel;
    logic [3:0]       r_lat_t;
    logic [3:0]       r_lat_o;

    logic             w_tick;
    logic [3:0]       w_digit;
    logic [6:0]       w_dec;
    logic [6:0]       w_seg_nxt;
    logic [1:0]       w_an_nxt;

    assign w_tick = (r_div == DIV_LAST);
    assign tick   = w_tick;

    // Prescaler, digit select and blink phase all advance on the scan tick
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div     <= '0;
            r_sel     <= SEL_ONES;
            r_blk_cnt <= '0;
            r_phase   <= 1'b0;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick) begin
                r_sel <= (r_sel == SEL_ONES) ? SEL_TENS : SEL_ONES;
                if (r_blk_cnt == BLK_LAST) begin
                    r_blk_cnt <= '0;
                    r_phase   <= ~r_phase;
                end else begin
                    r_blk_cnt <= r_blk_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lat_t <= 4'd0;
            r_lat_o <= 4'd0;
        end else if (load) begin
            r_lat_t <= tens;
            r_lat_o <= ones;
        end
    end

    assign w_digit = (r_sel == SEL_TENS) ? r_lat_t : r_lat_o;

    seg7_decode u_decode (
        .bcd (w_digit),
        .seg (w_dec)
    );

    // Blink outranks leading-zero blanking, which outranks the decoded digit
    always_comb begin
        w_seg_nxt = w_dec;
        w_an_nxt  = (r_sel == SEL_TENS) ? AN_TENS : AN_ONES;
        if (blink_en && r_phase) begin
            w_seg_nxt = SEG_OFF;
            w_an_nxt  = AN_OFF;
        end else if ((r_sel == SEL_TENS) && blank_lz && (r_lat_t == 4'd0)) begin
            w_seg_nxt = SEG_OFF;
            w_an_nxt  = AN_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= SEG_OFF;
            an  <= AN_OFF;
        end else begin
            seg <= w_seg_nxt;
            an  <= w_an_nxt;
        end
    end

endmodule : seg7_scan
`default_nettype wire

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter CLK_DIV, default 50000: clk cycles per scan tick; legal range >= 2.
REQ-002 Parameter BLINK_TICKS, default 250: scan ticks per blink half-period; legal range >= 1.
REQ-003 clk  input  1  system clock; the block uses one clock and all state changes on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 tens  input  4  BCD tens digit from the binary-to-BCD conversion stage.
REQ-006 ones  input  4  BCD ones digit from the binary-to-BCD conversion stage.
REQ-007 load  input  1  single-cycle strobe; captures tens/ones into the display latch.
REQ-008 blank_lz  input  1  when 1, the tens digit is blanked if the latched tens value is 0.
REQ-009 blink_en  input  1  when 1, both digits blink at the blink rate.
REQ-010 seg  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}.
REQ-011 an  output  2  digit anodes, active-low; an[0] drives ones and an[1] drives tens.
REQ-012 tick  output  1  one-cycle pulse marking each scan-digit change; for bench and status use.

Function
REQ-013 Prescaler: counts 0..CLK_DIV-1 and wraps; tick=1 in the cycle the count equals CLK_DIV-1.
REQ-014 Digit select sel: toggles in the cycle after tick; sel=0 selects ones and sel=1 selects tens.
REQ-015 Display latch: on a load=1 edge, lat_t<=tens and lat_o<=ones; otherwise the latch holds.
REQ-016 The latch does not update between loads; the input may change freely while the displayed value stays stable.
REQ-017 seg and an are registered; each reflects sel, the latch and the mode inputs as sampled at the previous edge (1-cycle latency).
REQ-018 Load timing: load at edge N updates the latch at N; seg shows the new value from edge N+1 if that digit is selected.
REQ-019 Decode table (active-low): 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
REQ-020 Non-BCD values (10..15): the digit shows a dash, seg=7'h3F.
REQ-021 Active digit enable: an=2'b10 when sel=0 and an=2'b01 when sel=1.
REQ-022 Leading-zero blank: when blank_lz=1, lat_t=0 and sel=1, an=2'b11 and seg=7'h7F.
REQ-023 The ones digit is never blanked by blank_lz, so a value of 00 displays as "0".
REQ-024 Blink: a tick counter counts 0..BLINK_TICKS-1; at wrap, the phase register toggles.
REQ-025 When blink_en=1 and phase=1: an=2'b11 and seg=7'h7F.
REQ-026 When blink_en=0, the display is never blanked by blink; the phase counter keeps running.
REQ-027 Simultaneous load and tick: both take effect at the same edge; there is no priority conflict.
REQ-028 Anodes never assert both digits at once (an=2'b00 is illegal in every cycle).
REQ-029 Blanking has priority over decoding; blink blanking has priority over leading-zero blanking, which has priority over normal display.

Reset
REQ-030 While rst=1 at an edge: prescaler=0, sel=0, blink counter=0, phase=0, lat_t=0, lat_o=0, tick=0, seg=7'h7F, an=2'b11.
REQ-031 First edge after rst deasserts: the display shows ones digit 0 (seg=7'h40, an=2'b10).
REQ-032 rst asserted mid-scan or mid-blink aborts immediately to the REQ-030 values; load is ignored while rst=1.

Structure
REQ-033 Package seg7_pkg holds the ten digit codes, the dash code SEG_DASH=7'h3F, SEG_OFF=7'h7F and the anode constants.
REQ-034 One combinational sub-module seg7_decode (4-bit BCD in, 7-bit active-low out) implements REQ-019/REQ-020; it is instantiated once after the digit mux.

Verification (bench uses CLK_DIV=4, BLINK_TICKS=2)
REQ-035 Reset release, no load -> tick every 4 cycles; an alternates 10/01; seg alternates 7'h40 (ones) and 7'h40 (tens).
REQ-036 load with tens=4, ones=2 -> ones slot seg=7'h24, tens slot seg=7'h19; a later change of the inputs without load leaves the display unchanged.
REQ-037 blank_lz=1, load 0/7 -> tens slot an=2'b11 and seg=7'h7F; ones slot seg=7'h78; load 0/0 -> ones shows 7'h40.
REQ-038 load tens=12, ones=9 -> tens slot seg=7'h3F, ones slot seg=7'h10.
REQ-039 blink_en=1 -> display dark (an=2'b11) for 2 ticks, then on for 2 ticks, repeating; the assertion checks an!=2'b00 in every cycle.
REQ-040 load coincident with tick, then rst pulsed mid-period -> the new value appears on the next slot; reset forces seg=7'h7F and an=2'b11 at the next edge.
